// File: rtl/lcd_pattern_writer_if.sv
// Pixel-FIFO write-side bundle: frame request/status plus the 8-bit FIFO write port.
interface lcd_pattern_writer_if;
    logic       Frame_Start;
    logic [1:0] Pattern;
    logic       FIFO_Full;
    logic       FIFO_WE;
    logic [7:0] FIFO_DI;
    logic       Busy;
    logic       Frame_Done;

    modport master (
        input  Frame_Start, Pattern, FIFO_Full,
        output FIFO_WE, FIFO_DI, Busy, Frame_Done
    );

    modport slave (
        output Frame_Start, Pattern, FIFO_Full,
        input  FIFO_WE, FIFO_DI, Busy, Frame_Done
    );
endinterface

// File: rtl/lcd_pattern_writer.sv
// Generates one RGB565 test-pattern frame per request and streams it, high byte first,
// into the 8-bit write port of the display FIFO while honouring FIFO_Full.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | waiting for Frame_Start; FIFO_DI parked at 8'h00
// S_WR_HI  | presenting pixel[15:8]; written when the FIFO is not full
// S_WR_LO  | presenting pixel[7:0]; on write, advance x/y or finish frame
module lcd_pattern_writer #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int BAR_W    = 100
) (
    input  logic                 CLK,
    input  logic                 nRST,
    lcd_pattern_writer_if.master bus
);

    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] SUB_LAST = BW'(BAR_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR_HI = 2'd1,
        S_WR_LO = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [1:0]    r_pattern;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [2:0]    r_bar_idx;
    logic [BW-1:0] r_bar_sub;
    logic          r_frame_done;

    logic          w_we;
    logic [7:0]    w_di;
    logic          w_start;
    logic          w_advance;
    logic          w_x_last;
    logic          w_last_pixel;
    logic [15:0]   w_pixel;
    logic [15:0]   w_bar_color;
    logic [5:0]    w_x_hi;
    logic          w_y_b4;

    assign w_start      = (r_state == S_IDLE) && bus.Frame_Start;
    assign w_x_last     = (r_x == X_LAST);
    assign w_last_pixel = w_x_last && (r_y == Y_LAST);

    // x[7:2] and y[4], zero-extended when the counters are narrower than the pattern needs
    generate
        if (XW >= 8) begin : g_x_wide
            assign w_x_hi = r_x[7:2];
        end else if (XW > 2) begin : g_x_mid
            assign w_x_hi = {{(8 - XW){1'b0}}, r_x[XW-1:2]};
        end else begin : g_x_narrow
            assign w_x_hi = 6'd0;
        end

        if (YW > 4) begin : g_y_wide
            assign w_y_b4 = r_y[4];
        end else begin : g_y_narrow
            assign w_y_b4 = 1'b0;
        end
    endgenerate

    always_comb begin
        w_bar_color = 16'h0000;
        case (r_bar_idx)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
    end

    always_comb begin
        w_pixel = 16'hFFFF;
        case (r_pattern)
            2'd0:    w_pixel = 16'hFFFF;
            2'd1:    w_pixel = w_bar_color;
            2'd2:    w_pixel = {w_x_hi[5:1], w_x_hi, w_x_hi[5:1]};
            default: w_pixel = (w_x_hi[2] ^ w_y_b4) ? 16'hFFFF : 16'h0000;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_we         = 1'b0;
        w_di         = 8'h00;
        w_advance    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Frame_Start) begin
                    w_next_state = S_WR_HI;
                end
            end
            S_WR_HI: begin
                w_di = w_pixel[15:8];
                if (!bus.FIFO_Full) begin
                    w_we         = 1'b1;
                    w_next_state = S_WR_LO;
                end
            end
            S_WR_LO: begin
                w_di = w_pixel[7:0];
                if (!bus.FIFO_Full) begin
                    w_we         = 1'b1;
                    w_advance    = 1'b1;
                    w_next_state = w_last_pixel ? S_IDLE : S_WR_HI;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bar index/sub-count track x / BAR_W incrementally; the index saturates at 7
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pattern    <= 2'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_bar_idx    <= 3'd0;
            r_bar_sub    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_advance && w_last_pixel;
            if (w_start) begin
                r_pattern <= bus.Pattern;
                r_x       <= '0;
                r_y       <= '0;
                r_bar_idx <= 3'd0;
                r_bar_sub <= '0;
            end else if (w_advance) begin
                if (w_x_last) begin
                    r_x       <= '0;
                    r_y       <= w_last_pixel ? '0 : r_y + 1'b1;
                    r_bar_idx <= 3'd0;
                    r_bar_sub <= '0;
                end else begin
                    r_x <= r_x + 1'b1;
                    if (r_bar_sub == SUB_LAST) begin
                        r_bar_sub <= '0;
                        if (r_bar_idx != 3'd7) begin
                            r_bar_idx <= r_bar_idx + 3'd1;
                        end
                    end else begin
                        r_bar_sub <= r_bar_sub + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.FIFO_WE    = w_we;
    assign bus.FIFO_DI    = w_di;
    assign bus.Busy       = (r_state != S_IDLE);
    assign bus.Frame_Done = r_frame_done;

endmodule
